// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit data-RAM controller.
// Width codes, FSM states and the width/alignment legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE,
        RESP
    } lsu_state_t;

    // 1 when the width code is illegal for this access or the
    // byte offset is misaligned for the access size.
    function automatic logic lsu_bad_width(
        input logic       wr,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = |off;
            F3_BU:   bad = wr;
            F3_HU:   bad = wr | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering for the data-RAM controller.
// Extracts/extends load lanes and merges store lanes into an old word.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane and extend it to 32 bits.
    always_comb begin
        byte_sel = rd_word_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
        load_o   = 32'h0;
        case (funct3_i)
            F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_o = {24'h0, byte_sel};
            F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_o = {16'h0, half_sel};
            F3_W:    load_o = rd_word_i;
            default: load_o = 32'h0;
        endcase
    end

    // Replace the addressed byte or half of the old word.
    always_comb begin
        merge_o = old_word_i;
        if (funct3_i[1:0] == 2'b00) begin
            merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
        end else if (funct3_i[1:0] == 2'b01) begin
            merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        end
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Data-RAM initiator between the MEM stage and a word-wide RAM.
// Handles sub-word loads, read-modify-write stores and fault screening.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_fault,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [AW-1:0] address,
    output logic [31:0]   write_data,
    input  logic [31:0]   read_data
);

    lsu_state_t    state_q, state_d;
    logic          write_q;
    logic [2:0]    f3_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          fault_q;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   old_q, old_d;

    logic          accept;
    logic          fault_in;
    logic [31:0]   lane_load;
    logic [31:0]   lane_merge;

    assign req_ready  = (state_q == IDLE);
    assign accept     = req_ready & req_valid;
    assign fault_in   = lsu_bad_width(req_write, req_funct3, req_addr[1:0])
                      | (|req_addr[31:AW+2]);

    assign address    = addr_q[AW+1:2];
    assign resp_valid = (state_q == RESP);
    assign resp_fault = resp_valid & fault_q;
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;

    lsu_byte_lane u_lane (
        .rd_word_i  (read_data),
        .old_word_i (old_q),
        .wdata_i    (wdata_q),
        .off_i      (addr_q[1:0]),
        .funct3_i   (f3_q),
        .load_o     (lane_load),
        .merge_o    (lane_merge)
    );

    // State, latched request and data registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            fault_q <= 1'b0;
            rdata_q <= 32'h0;
            old_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            old_q   <= old_d;
            if (accept) begin
                write_q <= req_write;
                f3_q    <= req_funct3;
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
                fault_q <= fault_in;
            end
        end
    end

    // Next state and RAM strobes, decoded from state only.
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        old_d      = old_q;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        write_data = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rdata_d = 32'h0;
                    state_d = fault_in ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!write_q) begin
                    MemRead = 1'b1;
                    rdata_d = lane_load;
                    state_d = RESP;
                end else if (f3_q == F3_W) begin
                    MemWrite   = 1'b1;
                    write_data = wdata_q;
                    state_d    = RESP;
                end else begin
                    MemRead = 1'b1;
                    old_d   = read_data;
                    state_d = MERGE;
                end
            end
            MERGE: begin
                MemWrite   = 1'b1;
                write_data = lane_merge;
                state_d    = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a 1024-word RAM model.
// Drives on the falling edge and samples there too.
module tb_lsu_mem_ctrl;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_fault;
    logic          MemRead;
    logic          MemWrite;
    logic [AW-1:0] address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;

    logic [31:0]   mem [DEPTH];
    logic          clr = 1'b1;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    lsu_mem_ctrl #(.DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    always #5 CLK = ~CLK;

    assign read_data = mem[address];

    always @(posedge CLK) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA5A5_0000 | i;
            mem[5] <= 32'h8899_AABB;
        end else if (MemWrite) begin
            mem[address] <= write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; returns latency, response and strobe counts.
    task automatic do_req(
        input  logic        wr,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        output int          lat,
        output logic [31:0] rd,
        output logic        flt,
        output int          nmr,
        output int          nmw,
        output logic [31:0] lastwd
    );
        lat = 0; rd = 32'hx; flt = 1'bx;
        nmr = 0; nmw = 0; lastwd = 32'h0;
        @(negedge CLK);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3;
        req_addr = addr; req_wdata = wd;
        @(posedge CLK);
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                req_valid = 1'b0; req_write = ~wr; req_funct3 = ~f3;
                req_addr = ~addr; req_wdata = ~wd;
            end
            if (MemRead) nmr++;
            if (MemWrite) begin nmw++; lastwd = write_data; end
            if (resp_valid) begin
                lat = c; rd = resp_rdata; flt = resp_fault;
                break;
            end
        end
    endtask

    initial begin
        int          lat, nmr, nmw, rdy, pulses, k;
        logic [31:0] rd, wdl;
        logic        flt;
        logic [31:0] got [3];

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rvalid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_fault", 32'(resp_fault), 32'd0);
        chk("rst_strobes", {30'h0, MemRead, MemWrite}, 32'd0);
        chk("rst_addr", 32'(address), 32'd0);
        chk("rst_wdata", write_data, 32'h0);
        clr = 1'b0;
        RESET_N = 1'b1;

        // Loads from word 5 = 8899_AABB
        do_req(1'b0, 3'b000, 32'h14, 32'h0, lat, rd, flt, nmr, nmw, wdl);
        chk("lb_data", rd, 32'hFFFF_FFBB);
        chk("lb_lat", 32'(lat), 32'd2);
        chk("lb_fault", 32'(flt), 32'd0);
        do_req(1'b0, 3'b100, 32'h17, 32'h0, lat, rd, flt, nmr, nmw, wdl);
        chk("lbu_data", rd, 32'h0000_0088);
        do_req(1'b0, 3'b101, 32'h16, 32'h0, lat, rd, flt, nmr, nmw, wdl);
        chk("lhu_data", rd, 32'h0000_8899);

        // SB read-modify-write
        do_req(1'b1, 3'b000, 32'h15, 32'h11, lat, rd, flt, nmr, nmw, wdl);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_mr", 32'(nmr), 32'd1);
        chk("sb_mw", 32'(nmw), 32'd1);
        chk("sb_wd", wdl, 32'h8899_11BB);
        chk("sb_rdata", rd, 32'h0);
        chk("sb_mem", mem[5], 32'h8899_11BB);
        do_req(1'b0, 3'b010, 32'h14, 32'h0, lat, rd, flt, nmr, nmw, wdl);
        chk("lw_after_sb", rd, 32'h8899_11BB);
        do_req(1'b0, 3'b001, 32'h16, 32'h0, lat, rd, flt, nmr, nmw, wdl);
        chk("lh_sign", rd, 32'hFFFF_8899);

        // Top word and out of range
        do_req(1'b1, 3'b010, 32'hFFC, 32'hDEAD_BEEF,
               lat, rd, flt, nmr, nmw, wdl);
        chk("sw_top_fault", 32'(flt), 32'd0);
        chk("sw_top_lat", 32'(lat), 32'd2);
        chk("sw_top_mem", mem[1023], 32'hDEAD_BEEF);
        do_req(1'b0, 3'b010, 32'h1000, 32'h0, lat, rd, flt, nmr, nmw, wdl);
        chk("oor_fault", 32'(flt), 32'd1);
        chk("oor_lat", 32'(lat), 32'd1);
        chk("oor_strobes", 32'(nmr + nmw), 32'd0);
        chk("oor_rdata", rd, 32'h0);

        // Misaligned and illegal codes
        do_req(1'b0, 3'b001, 32'h21, 32'h0, lat, rd, flt, nmr, nmw, wdl);
        chk("lh_mis_fault", 32'(flt), 32'd1);
        chk("lh_mis_rdata", rd, 32'h0);
        do_req(1'b1, 3'b010, 32'h22, 32'h1234_5678,
               lat, rd, flt, nmr, nmw, wdl);
        chk("sw_mis_fault", 32'(flt), 32'd1);
        chk("sw_mis_strobes", 32'(nmr + nmw), 32'd0);
        chk("sw_mis_mem", mem[8], 32'hA5A5_0008);
        do_req(1'b0, 3'b011, 32'h20, 32'h0, lat, rd, flt, nmr, nmw, wdl);
        chk("f3_011_fault", 32'(flt), 32'd1);
        chk("f3_011_rdata", rd, 32'h0);
        do_req(1'b1, 3'b100, 32'h20, 32'h55, lat, rd, flt, nmr, nmw, wdl);
        chk("sbu_fault", 32'(flt), 32'd1);
        chk("sbu_mem", mem[8], 32'hA5A5_0008);

        // Reset in MERGE of an SH to word 6
        @(negedge CLK);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h1A; req_wdata = 32'h0000_1234;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        @(posedge CLK);
        #1;
        chk("merge_mw_on", 32'(MemWrite), 32'd1);
        RESET_N = 1'b0;
        #1;
        chk("rst_mw_drop", 32'(MemWrite), 32'd0);
        chk("rst_mr_drop", 32'(MemRead), 32'd0);
        chk("rst_rv_drop", 32'(resp_valid), 32'd0);
        chk("rst_wd_zero", write_data, 32'h0);
        chk("rst_addr_zero", 32'(address), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("rst_ready_after", 32'(req_ready), 32'd1);
        chk("rst_no_resp", 32'(resp_valid), 32'd0);
        chk("merge_word_kept", mem[6], 32'hA5A5_0006);

        // Back-to-back LW, SW, LW with req_valid held high
        rdy = 0; pulses = 0; k = 0;
        for (int i = 0; i < 3; i++) got[i] = 32'hx;
        @(negedge CLK);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h14; req_wdata = 32'h0;
        for (int c = 0; c < 40 && pulses < 3; c++) begin
            if (req_ready) rdy++;
            if (resp_valid) begin
                if (req_ready) rdy += 100;
                got[pulses] = resp_rdata;
                pulses++;
                k++;
                if (k == 1) begin
                    req_write = 1'b1; req_addr = 32'h30;
                    req_wdata = 32'hCAFE_F00D;
                end else if (k == 2) begin
                    req_write = 1'b0; req_addr = 32'h30;
                    req_wdata = 32'h0;
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge CLK);
        end
        req_valid = 1'b0;
        chk("b2b_pulses", 32'(pulses), 32'd3);
        chk("b2b_ready_cycles", 32'(rdy), 32'd3);
        chk("b2b_r0", got[0], 32'h8899_11BB);
        chk("b2b_r1", got[1], 32'h0);
        chk("b2b_r2", got[2], 32'hCAFE_F00D);
        chk("b2b_mem", mem[12], 32'hCAFE_F00D);
        repeat (3) @(negedge CLK);
        chk("b2b_no_extra", 32'(resp_valid), 32'd0);
        chk("b2b_idle", 32'(req_ready), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
